// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-ported memory between the
// instruction-fetch port (read-only) and the load/store port (read/write).
module mem_arbiter #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_ack_o,
    output logic [DATA_W-1:0] f_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    input  logic [DATA_W-1:0] mem_out_i,
    output logic              _mem_read_o,
    output logic              _mem_write_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              f_ack_q, f_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              busy_q, busy_d;
    logic              grant_c;
    logic              grant_port_c;

    // Next-state, grant selection and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        f_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        grant_c      = 1'b0;
        grant_port_c = PORT_F;

        // In RESP only the port that was not just served may chain directly
        if (state_q == S_IDLE) begin
            if (f_req_i && d_req_i) begin
                grant_c      = 1'b1;
                grant_port_c = (last_grant_q == PORT_F) ? PORT_D : PORT_F;
            end else if (f_req_i) begin
                grant_c      = 1'b1;
                grant_port_c = PORT_F;
            end else if (d_req_i) begin
                grant_c      = 1'b1;
                grant_port_c = PORT_D;
            end
        end else if (state_q == S_RESP) begin
            if (gnt_q == PORT_F && d_req_i) begin
                grant_c      = 1'b1;
                grant_port_c = PORT_D;
            end else if (gnt_q == PORT_D && f_req_i) begin
                grant_c      = 1'b1;
                grant_port_c = PORT_F;
            end
        end

        case (state_q)
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (gnt_q == PORT_F) begin
                        f_ack_d = 1'b1;
                        if (!we_q) f_rdata_d = mem_out_i;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!we_q) d_rdata_d = mem_out_i;
                    end
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    mem_rd_d    = !we_q;
                    mem_wr_d    = we_q;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (grant_c) begin
            state_d      = S_ACCESS;
            cnt_d        = CNT_LOAD;
            last_grant_d = grant_port_c;
            gnt_d        = grant_port_c;
            if (grant_port_c == PORT_D) begin
                addr_d  = d_addr_i;
                wdata_d = d_wdata_i;
                we_d    = d_we_i;
            end else begin
                addr_d  = f_addr_i;
                wdata_d = '0;
                we_d    = 1'b0;
            end
            mem_addr_d  = addr_d;
            mem_wdata_d = wdata_d;
            mem_rd_d    = !we_d;
            mem_wr_d    = we_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT_F;
            gnt_q        <= PORT_F;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            f_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            f_ack_q      <= f_ack_d;
            d_ack_q      <= d_ack_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            busy_q       <= busy_d;
        end
    end

    assign f_ack_o          = f_ack_q;
    assign d_ack_o          = d_ack_q;
    assign f_rdata_o        = f_rdata_q;
    assign d_rdata_o        = d_rdata_q;
    assign mem_address_o    = mem_addr_q;
    assign mem_write_data_o = mem_wdata_q;
    assign _mem_read_o      = mem_rd_q;
    assign _mem_write_o     = mem_wr_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with single-cycle access plus a
// memory model, one with three-cycle access for the mid-access reset case.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance with ACCESS_CYCLES = 1
    logic        rst_n;
    logic        f_req, d_req, d_we;
    logic [15:0] f_addr, d_addr, d_wdata;
    logic        f_ack, d_ack, rd, wr, busy;
    logic [15:0] f_rdata, d_rdata, mem_address, mem_write_data, mem_out;
    logic [15:0] mem [0:255];

    // Instance with ACCESS_CYCLES = 3
    logic        rst3_n;
    logic        f_req3, d_req3, d_we3;
    logic [15:0] f_addr3, d_addr3, d_wdata3;
    logic        f_ack3, d_ack3, rd3, wr3, busy3;
    logic [15:0] f_rdata3, d_rdata3, mem_address3, mem_write_data3, mem_out3;

    int nf, nd;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_ack_o(f_ack), .f_rdata_o(f_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ack_o(d_ack), .d_rdata_o(d_rdata),
        .mem_address_o(mem_address), .mem_write_data_o(mem_write_data),
        .mem_out_i(mem_out), ._mem_read_o(rd), ._mem_write_o(wr), .busy_o(busy)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n),
        .f_req_i(f_req3), .f_addr_i(f_addr3), .f_ack_o(f_ack3), .f_rdata_o(f_rdata3),
        .d_req_i(d_req3), .d_we_i(d_we3), .d_addr_i(d_addr3), .d_wdata_i(d_wdata3),
        .d_ack_o(d_ack3), .d_rdata_o(d_rdata3),
        .mem_address_o(mem_address3), .mem_write_data_o(mem_write_data3),
        .mem_out_i(mem_out3), ._mem_read_o(rd3), ._mem_write_o(wr3), .busy_o(busy3)
    );

    // Combinational-read memory; word 0x0001 is preloaded while in reset
    always @(posedge clk) begin
        if (!rst_n) mem[1] <= 16'h1234;
        else if (wr) mem[mem_address[7:0]] <= mem_write_data;
    end
    assign mem_out  = mem[mem_address[7:0]];
    assign mem_out3 = mem_address3 ^ 16'hA5A5;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;  rst3_n = 1'b0;
        f_req = 1'b1;  d_req = 1'b1;  d_we = 1'b1;
        f_addr = 16'hBEEF; d_addr = 16'h5A5A; d_wdata = 16'h7777;
        f_req3 = 1'b1; d_req3 = 1'b1; d_we3 = 1'b1;
        f_addr3 = 16'h1111; d_addr3 = 16'h2222; d_wdata3 = 16'h3333;

        // Reset with arbitrary inputs
        tick(); tick();
        chk("rst_f_ack", f_ack, 0);           chk("rst_d_ack", d_ack, 0);
        chk("rst_f_rdata", f_rdata, 0);       chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_write_data", mem_write_data, 0);
        chk("rst_rd", rd, 0);  chk("rst_wr", wr, 0);  chk("rst_busy", busy, 0);
        chk("rst3_busy", busy3, 0);  chk("rst3_rd", rd3, 0);

        f_req = 1'b0;  d_req = 1'b0;  d_we = 1'b0;
        f_req3 = 1'b0; d_req3 = 1'b0; d_we3 = 1'b0;
        d_addr3 = 16'h0; d_wdata3 = 16'h0;
        rst_n = 1'b1;  rst3_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Fetch read of word 0x0001
        f_req = 1'b1; f_addr = 16'h0001;
        tick();
        chk("fetch_rd", rd, 1);  chk("fetch_wr", wr, 0);
        chk("fetch_addr", mem_address, 16'h0001);  chk("fetch_busy", busy, 1);
        tick();
        chk("fetch_ack", f_ack, 1);  chk("fetch_rdata", f_rdata, 16'h1234);
        chk("fetch_resp_rd", rd, 0); chk("fetch_resp_addr", mem_address, 0);
        chk("fetch_no_d_ack", d_ack, 0);
        tick();
        f_req = 1'b0;
        chk("fetch_req_ignored_busy", busy, 0);  chk("fetch_ack_pulse", f_ack, 0);

        // Data write 0xC003 to 0x0083
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0083; d_wdata = 16'hC003;
        tick();
        chk("wr_strobe", wr, 1);  chk("wr_no_rd", rd, 0);
        chk("wr_addr", mem_address, 16'h0083);  chk("wr_data", mem_write_data, 16'hC003);
        tick();
        chk("wr_ack", d_ack, 1);  chk("wr_strobe_off", wr, 0);
        chk("wr_rdata_kept", d_rdata, 0);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        chk("wr_idle", busy, 0);

        // Data read back of 0x0083
        d_req = 1'b1; d_wdata = 16'h0000;
        tick();
        chk("rd_strobe", rd, 1);  chk("rd_addr", mem_address, 16'h0083);
        tick();
        chk("rd_ack", d_ack, 1);  chk("rd_rdata", d_rdata, 16'hC003);
        tick();
        d_req = 1'b0;

        // Contention straight out of reset: D wins, F chains without IDLE
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_d_rdata", d_rdata, 0);
        f_req = 1'b1; f_addr = 16'h0001;
        d_req = 1'b1; d_addr = 16'h0083; d_we = 1'b0;
        tick();
        chk("cont_d_bus", mem_address, 16'h0083);  chk("cont_d_rd", rd, 1);
        tick();
        chk("cont_d_ack", d_ack, 1);  chk("cont_f_wait", f_ack, 0);
        chk("cont_d_rdata", d_rdata, 16'hC003);
        tick();
        d_req = 1'b0;
        chk("cont_f_bus", mem_address, 16'h0001);  chk("cont_f_rd", rd, 1);
        chk("cont_no_idle", busy, 1);
        tick();
        chk("cont_f_ack", f_ack, 1);  chk("cont_f_rdata", f_rdata, 16'h1234);
        tick();
        f_req = 1'b0;
        chk("cont_idle", busy, 0);

        // Fairness: both ports request continuously for 8 accesses
        f_req = 1'b1; d_req = 1'b1;
        nf = 0; nd = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (f_ack) nf++;
            if (d_ack) nd++;
            chk("fair_d_ack", d_ack, (i % 4 == 2));
            chk("fair_f_ack", f_ack, (i % 4 == 0));
            chk("fair_excl", rd & wr, 0);
        end
        f_req = 1'b0; d_req = 1'b0;
        chk("fair_f_count", nf, 4);  chk("fair_d_count", nd, 4);
        tick();
        chk("fair_idle", busy, 0);

        // Reset in the second strobe cycle of a three-cycle access
        f_req3 = 1'b1; f_addr3 = 16'h0042;
        tick();
        chk("abort_strobe1", rd3, 1);
        tick();
        chk("abort_strobe2", rd3, 1);
        rst3_n = 1'b0;
        tick();
        chk("abort_rd_off", rd3, 0);  chk("abort_no_ack", f_ack3, 0);
        chk("abort_rdata", f_rdata3, 0);  chk("abort_busy", busy3, 0);
        rst3_n = 1'b1;
        tick();
        chk("retry_strobe1", rd3, 1);  chk("retry_addr1", mem_address3, 16'h0042);
        tick();
        f_addr3 = 16'h0099;
        chk("retry_strobe2", rd3, 1);  chk("retry_no_early_ack", f_ack3, 0);
        tick();
        chk("retry_strobe3", rd3, 1);  chk("retry_addr_held", mem_address3, 16'h0042);
        tick();
        chk("retry_ack", f_ack3, 1);  chk("retry_rdata", f_rdata3, 16'hA5E7);
        chk("retry_rd_off", rd3, 0);
        tick();
        f_req3 = 1'b0;
        chk("retry_ack_pulse", f_ack3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
